pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Multi-cycle fetch/issue controller for KGP-miniRISC. Owns the PC register, fetches from
//  instruction memory via req/ack, issues each instruction once, waits for execute, then
//  loads the next PC from branch_control (pc_new) and writes the link register on calls.
//  Holds halted/error state and a retired-instruction counter.
// PARAMETERS
//  RESET_PC       32'h0000_0000  PC value loaded on reset
//  FETCH_TIMEOUT  16             max cycles FETCH waits for imem_ack before error
//  CNT_W          32             width of retired-instruction counter
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      synchronous reset, active-high
//  run            in   1      start execution; sampled only in IDLE
//  imem_req       out  1      instruction fetch request
//  imem_addr      out  32     fetch address (= pc)
//  imem_ack       in   1      fetch complete; imem_data valid this cycle
//  imem_data      in   32     fetched instruction word
//  instr          out  32     latched instruction for decode
//  instr_valid    out  1      one-cycle issue pulse
//  ex_done        in   1      execute finished current instruction; br_op/pc_new valid
//  halt_instr     in   1      current instruction is halt (qualified by ex_done)
//  br_op          in   5      branch opcode of current instruction
//  pc_new         in   32     next PC from branch_control
//  pc_branch_link in   32     link value from branch_control
//  pc             out  32     current PC (drives branch_control pc input)
//  link_we        out  1      one-cycle link-register write strobe
//  link_data      out  32     link value to register file
//  halted         out  1      sticky; set on halt or fetch error
//  fetch_err      out  1      sticky; fetch timeout occurred
//  retired        out  CNT_W  count of accepted ex_done events, wraps mod 2^CNT_W
// BEHAVIOUR
//  Reset: pc=RESET_PC, state IDLE, instr=0, all strobes/flags=0, retired=0, timeout cnt=0.
//  States: IDLE, FETCH, ISSUE, EXEC, HALTED.
//  IDLE: run=1 -> FETCH. imem_req asserted in first FETCH cycle (1 cycle after run).
//  FETCH: imem_req=1, imem_addr=pc. imem_ack -> instr<=imem_data, -> ISSUE. Counter counts
//   cycles without ack; reaching FETCH_TIMEOUT -> fetch_err=1, halted=1, -> HALTED.
//   ack in the same cycle timeout is reached: ack wins, no error.
//  ISSUE: instr_valid=1 exactly one cycle -> EXEC.
//  EXEC: wait for ex_done. On ex_done: retired+=1; if halt_instr -> HALTED, halted=1, pc
//   unchanged, no link_we (halt wins over call). Else pc<=pc_new; if br_op[2:0]==3'b101
//   link_we=1 next cycle with link_data=pc_branch_link captured at ex_done; -> FETCH.
//  Latency: ex_done at cycle j -> pc updated, imem_req with new address at j+1.
//  HALTED: terminal until rst; imem_req=0, no issue.
//  Ignored: imem_ack outside FETCH, ex_done outside EXEC, run outside IDLE.
//  PC wrap (e.g. 0xFFFFFFFC -> 0) is latched as given; no controller arithmetic on PC.
//  rst mid-fetch/mid-exec: abort immediately, outstanding ack next cycle ignored (IDLE).
// CONFIGURATION
//  PC_ALIGN_TRAP_EN defined: on ex_done (non-halt) with pc_new[1:0]!=2'b00, pc unchanged,
//   no link_we, adds outputs trap (1, sticky) and trap_pc (32, =pc_new), -> HALTED.
//  Not defined: no trap ports; pc_new loaded unchecked, low bits passed through.
// TESTING
//  rst; run=1, ack after 2 cycles with 0x2000_0001 -> imem_addr=0, instr_valid pulse, instr=0x2000_0001
//  ex_done, br_op=5'b00000, pc_new=4 -> pc=4 next cycle, imem_addr=4, retired=1
//  ex_done, br_op=5'b00101, pc_new=0x40, link=0x8 -> link_we 1 cycle, link_data=0x8, pc=0x40
//  FETCH with no ack for 16 cycles -> fetch_err=1, halted=1, imem_req=0; later ack ignored
//  ex_done with halt_instr=1, br_op=5'b00101 -> halted=1, no link_we, pc unchanged
//  PC_ALIGN_TRAP_EN: pc_new=0x42 -> trap=1, trap_pc=0x42, halted=1; rst mid-EXEC -> pc=RESET_PC, IDLE

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch/issue/execute sequencer for KGP-miniRISC: owns the PC, fetches over req/ack, issues once, retires.
// Optional build macro PC_ALIGN_TRAP_EN: misaligned pc_new traps to HALTED and exposes trap/trap_pc.
//
// state   | meaning
// IDLE    | waiting for run
// FETCH   | imem_req high at pc, timeout timer running
// ISSUE   | instr_valid pulse for the latched instruction
// EXEC    | waiting for ex_done, then load pc_new / link
// HALTED  | terminal until rst (halt instruction, fetch timeout or trap)
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_data,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             ex_done,
  input  logic             halt_instr,
  input  logic [4:0]       br_op,
  input  logic [31:0]      pc_new,
  input  logic [31:0]      pc_branch_link,
  output logic [31:0]      pc,
  output logic             link_we,
  output logic [31:0]      link_data,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired
`ifdef PC_ALIGN_TRAP_EN
  ,
  output logic             trap,
  output logic [31:0]      trap_pc
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  localparam int             TMR_W    = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FETCH_TIMEOUT - 1);

  logic [2:0]       state;
  logic [TMR_W-1:0] tmr;
  logic             is_call;
  logic             unused_br;

  assign is_call     = (br_op[2:0] == 3'b101);
  assign unused_br   = ^br_op[4:3];
  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_ISSUE);

  // tmr is a down-counter reloaded on every FETCH entry; reaching zero without ack is the timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      instr     <= 32'h0;
      tmr       <= '0;
      link_we   <= 1'b0;
      link_data <= 32'h0;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
      retired   <= '0;
`ifdef PC_ALIGN_TRAP_EN
      trap      <= 1'b0;
      trap_pc   <= 32'h0;
`endif
    end else begin
      link_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_FETCH;
            tmr   <= TMR_LOAD;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr <= imem_data;
            state <= ST_ISSUE;
          end else if (tmr == '0) begin
            fetch_err <= 1'b1;
            halted    <= 1'b1;
            state     <= ST_HALTED;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        ST_ISSUE: state <= ST_EXEC;
        ST_EXEC: begin
          if (ex_done) begin
            retired <= retired + CNT_W'(1);
            if (halt_instr) begin
              halted <= 1'b1;
              state  <= ST_HALTED;
            end
`ifdef PC_ALIGN_TRAP_EN
            else if (pc_new[1:0] != 2'b00) begin
              trap    <= 1'b1;
              trap_pc <= pc_new;
              halted  <= 1'b1;
              state   <= ST_HALTED;
            end
`endif
            else begin
              pc    <= pc_new;
              state <= ST_FETCH;
              tmr   <= TMR_LOAD;
              if (is_call) begin
                link_we   <= 1'b1;
                link_data <= pc_branch_link;
              end
            end
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule
